// File: rtl/window_gen_3x3.sv
`default_nettype none
// ============================================================================
// Module  : window_gen_3x3
// Brief   : Line-buffered 3x3 RGB window generator and coefficient forwarder.
// Rev     : 1.0  initial release
// ============================================================================
module window_gen_3x3 #(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int PIX_W   = 24,
    parameter int WIN_GAP = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PIX_W-1:0]     coef_in,
    input  logic                 coef_valid,
    output logic                 coef_ready,
    input  logic                 start,
    input  logic [PIX_W-1:0]     pix_in,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic [9*PIX_W-1:0]   win_data,
    output logic                 win_valid,
    output logic                 win_tc_set,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int GW = $clog2(WIN_GAP + 1);

    localparam logic [CW-1:0] c_COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] c_ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] c_COL_TWO  = CW'(2);
    localparam logic [RW-1:0] c_ROW_TWO  = RW'(2);
    localparam logic [GW-1:0] c_GAP      = GW'(WIN_GAP);
    localparam logic [3:0]    c_NUM_COEF = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_coef_cnt;
    logic [RW-1:0]      r_row;
    logic [CW-1:0]      r_col;
    logic [GW-1:0]      r_gap;

    logic [PIX_W-1:0]   r_lb0 [IMG_W];
    logic [PIX_W-1:0]   r_lb1 [IMG_W];
    logic [PIX_W-1:0]   r_pc1 [3];
    logic [PIX_W-1:0]   r_pc2 [3];
    logic [PIX_W-1:0]   w_col_new [3];
    logic [9*PIX_W-1:0] w_win_next;

    logic               r_win_valid;
    logic               r_win_tc_set;
    logic [9*PIX_W-1:0] r_win_data;
    logic               r_frame_done;

    logic               w_coef_rdy;
    logic               w_pix_rdy;
    logic               w_busy;
    logic               w_done_fire;
    logic               w_coef_acc;
    logic               w_pix_acc;
    logic               w_win_fire;
    logic               w_last_pix;

    assign w_coef_acc = coef_valid & w_coef_rdy;
    assign w_pix_acc  = pix_valid & w_pix_rdy;
    assign w_last_pix = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
    assign w_win_fire = w_pix_acc && (r_row >= c_ROW_TWO) && (r_col >= c_COL_TWO);

    always_comb begin
        w_next      = r_state;
        w_coef_rdy  = 1'b0;
        w_pix_rdy   = 1'b0;
        w_busy      = 1'b0;
        w_done_fire = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_coef_rdy = 1'b1;
                if (start && (r_coef_cnt == c_NUM_COEF) && !coef_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_busy    = 1'b1;
                w_pix_rdy = (r_gap == '0);
                if (pix_valid && w_pix_rdy && w_last_pix) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_busy = 1'b1;
                if (r_gap == '0) begin
                    w_done_fire = 1'b1;
                    w_next      = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Column entering the window: two buffered lines above plus the live pixel.
    assign w_col_new[0] = r_lb0[r_col];
    assign w_col_new[1] = r_lb1[r_col];
    assign w_col_new[2] = pix_in;

    for (genvar gr = 0; gr < 3; gr++) begin : g_row
        assign w_win_next[(gr*3+0)*PIX_W +: PIX_W] = r_pc2[gr];
        assign w_win_next[(gr*3+1)*PIX_W +: PIX_W] = r_pc1[gr];
        assign w_win_next[(gr*3+2)*PIX_W +: PIX_W] = w_col_new[gr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_coef_cnt <= 4'd0;
            r_row      <= '0;
            r_col      <= '0;
            r_gap      <= '0;
            r_pc1      <= '{default: '0};
            r_pc2      <= '{default: '0};
        end else begin
            r_state <= w_next;

            if (w_coef_acc) begin
                r_coef_cnt <= (r_coef_cnt == c_NUM_COEF) ? 4'd1 : r_coef_cnt + 4'd1;
            end

            if (w_win_fire) begin
                r_gap <= c_GAP;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end

            if (w_done_fire) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_pix_acc) begin
                if (r_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            if (w_pix_acc) begin
                r_pc2 <= r_pc1;
                r_pc1 <= w_col_new;
            end
        end
    end

    // Line storage needs no reset: a location is always written before it feeds a window.
    always_ff @(posedge clk) begin
        if (w_pix_acc) begin
            r_lb0[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_valid  <= 1'b0;
            r_win_tc_set <= 1'b0;
            r_win_data   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= w_coef_acc | w_win_fire;
            r_win_tc_set <= w_coef_acc;
            r_frame_done <= w_done_fire;
            if (w_coef_acc) begin
                r_win_data <= {{(8*PIX_W){1'b0}}, coef_in};
            end else if (w_win_fire) begin
                r_win_data <= w_win_next;
            end
        end
    end

    assign coef_ready = w_coef_rdy;
    assign pix_ready  = w_pix_rdy;
    assign busy       = w_busy;
    assign win_valid  = r_win_valid;
    assign win_tc_set = r_win_tc_set;
    assign win_data   = r_win_data;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_window_gen_3x3.sv
`default_nettype none
// ============================================================================
// Module  : tb_window_gen_3x3
// Brief   : Directed self-checking bench for window_gen_3x3 on a 4x4 frame.
// Rev     : 1.0  initial release
// ============================================================================
module tb_window_gen_3x3;

    localparam int IMG_W   = 4;
    localparam int IMG_H   = 4;
    localparam int PIX_W   = 24;
    localparam int WIN_GAP = 3;
    localparam int NPIX    = IMG_W * IMG_H;

    logic           clk;
    logic           rst_n;
    logic [23:0]    coef_in;
    logic           coef_valid;
    logic           coef_ready;
    logic           start;
    logic [23:0]    pix_in;
    logic           pix_valid;
    logic           pix_ready;
    logic [215:0]   win_data;
    logic           win_valid;
    logic           win_tc_set;
    logic           busy;
    logic           frame_done;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state
    bit mon_en  = 0;
    bit exp_wv  = 0;
    int exp_idx = 0;
    int acc_idx = 0;
    int n_win   = 0;
    int fd_cnt  = 0;
    bit in_gap  = 0;
    int gap_len = 0;

    window_gen_3x3 #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .PIX_W   (PIX_W),
        .WIN_GAP (WIN_GAP)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coef_in    (coef_in),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .start      (start),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .win_data   (win_data),
        .win_valid  (win_valid),
        .win_tc_set (win_tc_set),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [215:0] got, input logic [215:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pixval(input int k);
        return {8'(k / IMG_W), 8'(k % IMG_W), 8'(k)};
    endfunction

    function automatic logic [215:0] exp_window(input int idx);
        logic [215:0] w;
        int r;
        int c;
        r = idx / IMG_W;
        c = idx % IMG_W;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[k*24 +: 24] = pixval((r - 2 + k / 3) * IMG_W + (c - 2 + k % 3));
        end
        return w;
    endfunction

    // Window / acceptance / gap / frame_done monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (mon_en) begin
            check("win_valid", 216'(win_valid), 216'(exp_wv));
            if (exp_wv) begin
                check("win_data", win_data, exp_window(exp_idx));
                check("win_tc_set", 216'(win_tc_set), 216'(0));
                n_win++;
            end
            if (win_valid) begin
                in_gap  = 1;
                gap_len = pix_ready ? 0 : 1;
            end else if (in_gap) begin
                if (pix_ready) begin
                    check("gap_len", 216'(gap_len), 216'(WIN_GAP));
                    in_gap = 0;
                end else begin
                    gap_len++;
                end
            end
            if (frame_done) begin
                fd_cnt++;
                check("fd_after_last", 216'(acc_idx), 216'(NPIX));
            end
            if (pix_valid && pix_ready) begin
                check("acc_pix", 216'(pix_in), 216'(pixval(acc_idx)));
                exp_idx = acc_idx;
                exp_wv  = ((acc_idx / IMG_W) >= 2) && ((acc_idx % IMG_W) >= 2);
                acc_idx++;
            end else begin
                exp_wv = 0;
            end
        end
    end

    task automatic load_coefs(input int n, input int base, input bit start_last);
        for (int i = 0; i < n; i++) begin
            coef_in    = 24'(base + i);
            coef_valid = 1'b1;
            start      = start_last && (i == n - 1);
            @(posedge clk); #1;
            check("coef_wv", 216'(win_valid), 216'(1));
            check("coef_tc", 216'(win_tc_set), 216'(1));
            check("coef_data", win_data, 216'(base + i));
        end
        coef_valid = 1'b0;
        start      = 1'b0;
        @(posedge clk); #1;
        check("coef_end_wv", 216'(win_valid), 216'(0));
        check("coef_hold", win_data, 216'(base + n - 1));
        check("coef_busy", 216'(busy), 216'(0));
    endtask

    task automatic feed_pixels(input int count, input bit gaps);
        int k;
        int cyc;
        bit acc;
        k   = 0;
        cyc = 0;
        while (k < count && cyc < 1000) begin
            pix_in    = pixval(k);
            pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = pix_valid && pix_ready;
            @(posedge clk); #1;
            if (acc) k++;
            cyc++;
        end
        pix_valid = 1'b0;
        if (k < count) check("feed_timeout", 216'(k), 216'(count));
    endtask

    task automatic run_frame(input bit gaps);
        int cyc;
        acc_idx = 0;
        n_win   = 0;
        fd_cnt  = 0;
        in_gap  = 0;
        exp_wv  = 0;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        check("frame_busy", 216'(busy), 216'(1));
        check("frame_coef_rdy", 216'(coef_ready), 216'(0));
        mon_en = 1;
        feed_pixels(NPIX, gaps);
        cyc = 0;
        while (fd_cnt == 0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (2) @(posedge clk);
        #1;
        mon_en = 0;
        check("frame_done_cnt", 216'(fd_cnt), 216'(1));
        check("win_count", 216'(n_win), 216'((IMG_W - 2) * (IMG_H - 2)));
        check("acc_count", 216'(acc_idx), 216'(NPIX));
        check("end_busy", 216'(busy), 216'(0));
        check("end_coef_rdy", 216'(coef_ready), 216'(1));
    endtask

    initial begin
        rst_n      = 1'b0;
        coef_in    = '0;
        coef_valid = 1'b0;
        start      = 1'b0;
        pix_in     = '0;
        pix_valid  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_wv", 216'(win_valid), 216'(0));
        check("rst_tc", 216'(win_tc_set), 216'(0));
        check("rst_data", win_data, 216'(0));
        check("rst_fd", 216'(frame_done), 216'(0));
        check("rst_busy", 216'(busy), 216'(0));
        check("rst_pix_rdy", 216'(pix_ready), 216'(0));
        check("rst_coef_rdy", 216'(coef_ready), 216'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // start with no coefficients loaded
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_nocoef", 216'(busy), 216'(0));

        // asynchronous reset while a coefficient beat is on the outputs
        coef_in    = 24'h000055;
        coef_valid = 1'b1;
        @(posedge clk); #1;
        coef_valid = 1'b0;
        check("pre_rst_wv", 216'(win_valid), 216'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wv", 216'(win_valid), 216'(0));
        check("mid_rst_tc", 216'(win_tc_set), 216'(0));
        check("mid_rst_data", win_data, 216'(0));
        check("mid_rst_coef_rdy", 216'(coef_ready), 216'(1));
        #1 rst_n = 1'b1;

        // 9 words back-to-back, start raised with the 9th (count is still 8)
        load_coefs(9, 1, 1'b1);

        run_frame(1'b0);
        run_frame(1'b1);
        run_frame(1'b0);

        // one word restarts the count; start ignored until 8 more arrive
        load_coefs(1, 16, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_partial", 216'(busy), 216'(0));
        load_coefs(8, 32, 1'b0);
        run_frame(1'b0);

        // reset partway through a frame
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("part_busy", 216'(busy), 216'(1));
        feed_pixels(9, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("part_rst_busy", 216'(busy), 216'(0));
        check("part_rst_pix_rdy", 216'(pix_ready), 216'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_after_rst", 216'(busy), 216'(0));
        load_coefs(9, 64, 1'b0);
        run_frame(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
